rram_host_loader: RTL

Packet loader directly upstream of the RRAM core's external instruction and input-data FIFOs. It accepts a 64-bit valid/ready word stream from the host and parses it into headers and payload. Instruction payload is unpacked, three 20-bit instructions per word, and pushed into the instruction FIFO; data payload is pushed word-for-word into the input-data FIFO. Packets addressed to another core are consumed and dropped.

---
 rtl/rram_loader_pkg.sv | 24 ++
 rtl/rram_instr_unpacker.sv | 60 ++++++
 rtl/rram_host_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rram_loader_pkg.sv
// Shared types and header layout for the RRAM host loader.
package rram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  localparam logic [3:0] TYPE_INSTR = 4'h1;
  localparam logic [3:0] TYPE_DATA  = 4'h2;

  localparam int HDR_TYPE_LSB = 60;
  localparam int HDR_TYPE_W   = 4;
  localparam int HDR_CORE_LSB = 58;
  localparam int HDR_CORE_W   = 2;
  localparam int HDR_LEN_LSB  = 0;

  localparam int INSTR_WIDTH_DFLT  = 4;
  localparam int OPCODE_WIDTH_DFLT = 16;
  localparam int INSTR_W = INSTR_WIDTH_DFLT + OPCODE_WIDTH_DFLT;

endpackage

// File: rtl/rram_instr_unpacker.sv
// Holds one payload word and emits its three instruction slots, one per cycle.
// A slot waits while the FIFO is full; din stays on that slot until it goes.
module rram_instr_unpacker
  import rram_loader_pkg::*;
#(
  parameter int W  = INSTR_W,
  parameter int LW = 16
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [3*W-1:0] i_data,
  input  logic [LW-1:0] i_cnt,
  input  logic          i_full,
  output logic          o_buf_vld,
  output logic          o_push,
  output logic          o_push_n,
  output logic [W-1:0]  o_din
);

  logic [3*W-1:0] r_buf;
  logic           r_buf_vld;
  logic [1:0]     r_slot;
  logic           w_last;

  assign o_push    = r_buf_vld & ~i_full & rst_n;
  assign o_push_n  = ~o_push;
  assign o_buf_vld = r_buf_vld;
  // The word is finished after slot 2 or when this push drains the packet.
  assign w_last    = (r_slot == 2'd2) || (i_cnt == LW'(1));

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_buf_vld <= 1'b0;
      r_slot    <= 2'd0;
    end else if (i_load) begin
      r_buf     <= i_data;
      r_buf_vld <= 1'b1;
      r_slot    <= 2'd0;
    end else if (o_push) begin
      if (w_last) begin
        r_buf_vld <= 1'b0;
        r_slot    <= 2'd0;
      end else begin
        r_slot <= r_slot + 2'd1;
      end
    end
  end

  always_comb begin
    o_din = r_buf[W-1:0];
    case (r_slot)
      2'd0:    o_din = r_buf[W-1:0];
      2'd1:    o_din = r_buf[2*W-1:W];
      default: o_din = r_buf[3*W-1:2*W];
    endcase
  end

endmodule

// File: rtl/rram_host_loader.sv
// Parses host packets into instruction / input-data FIFO pushes; DATA words pass with zero latency,
// INSTR words unpack at one slot per cycle. Host is stalled via s_ready; FIFO full stalls pushes combinationally.
module rram_host_loader
  import rram_loader_pkg::*;
#(
  parameter int INSTR_WIDTH  = 4,
  parameter int OPCODE_WIDTH = 16,
  parameter int DATAIN_WIDTH = 64,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                              CLK,
  input  logic                              rst_n,
  input  logic [1:0]                        CORE_SEL,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATAIN_WIDTH-1:0]           s_data,
  output logic                              push_n_instFIFO,
  input  logic                              full_instFIFO,
  output logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] din_instFIFO,
  output logic                              push_n_iFIFO,
  input  logic                              full_iFIFO,
  output logic [DATAIN_WIDTH-1:0]           din_iFIFO,
  output logic                              busy,
  output logic                              pkt_done,
  output logic                              err_hdr
);

  localparam int IW = INSTR_WIDTH + OPCODE_WIDTH;

  state_t               r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt, w_dec;
  logic                 r_drop_instr, w_drop_instr_nxt;
  logic                 r_pkt_done, w_done_nxt;
  logic                 r_err_hdr, w_err_nxt;
  logic                 w_s_ready, w_push_i, w_load;
  logic                 w_buf_vld, w_ins_push;
  logic [3:0]           w_type;
  logic [1:0]           w_core;
  logic [LEN_WIDTH-1:0] w_len;

  assign w_type = s_data[HDR_TYPE_LSB +: HDR_TYPE_W];
  assign w_core = s_data[HDR_CORE_LSB +: HDR_CORE_W];
  assign w_len  = s_data[HDR_LEN_LSB +: LEN_WIDTH];

  rram_instr_unpacker #(.W(IW), .LW(LEN_WIDTH)) u_unpack (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_data    (s_data[3*IW-1:0]),
    .i_cnt     (r_cnt),
    .i_full    (full_instFIFO),
    .o_buf_vld (w_buf_vld),
    .o_push    (w_ins_push),
    .o_push_n  (push_n_instFIFO),
    .o_din     (din_instFIFO)
  );

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_drop_instr <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_err_hdr    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_drop_instr <= w_drop_instr_nxt;
      r_pkt_done   <= w_done_nxt;
      r_err_hdr    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_drop_instr_nxt = r_drop_instr;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    w_s_ready        = 1'b0;
    w_push_i         = 1'b0;
    w_load           = 1'b0;
    w_dec            = LEN_WIDTH'(1);
    case (r_state)
      ST_IDLE: begin
        w_s_ready = 1'b1;
        if (s_valid) begin
          w_cnt_nxt = w_len;
          if (w_type != TYPE_INSTR && w_type != TYPE_DATA) begin
            w_err_nxt = 1'b1;
          end else if (w_len == '0) begin
            w_done_nxt = 1'b1;
          end else if (w_core != CORE_SEL) begin
            w_state_nxt      = ST_DROP;
            w_drop_instr_nxt = (w_type == TYPE_INSTR);
          end else begin
            w_state_nxt = (w_type == TYPE_INSTR) ? ST_INSTR : ST_DATA;
          end
        end
      end
      ST_INSTR: begin
        w_s_ready = ~w_buf_vld;
        w_load    = s_valid & ~w_buf_vld;
        if (w_ins_push) begin
          w_cnt_nxt = r_cnt - LEN_WIDTH'(1);
          if (r_cnt == LEN_WIDTH'(1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        w_s_ready = ~full_iFIFO;
        w_push_i  = s_valid & ~full_iFIFO;
        if (w_push_i) begin
          w_cnt_nxt = r_cnt - LEN_WIDTH'(1);
          if (r_cnt == LEN_WIDTH'(1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_s_ready = 1'b1;
        // A dropped INSTR word carries up to three instructions.
        if (r_drop_instr)
          w_dec = (r_cnt < LEN_WIDTH'(3)) ? r_cnt : LEN_WIDTH'(3);
        if (s_valid) begin
          w_cnt_nxt = r_cnt - w_dec;
          if (r_cnt <= w_dec) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
    endcase
    if (!rst_n) begin
      w_s_ready = 1'b0;
      w_push_i  = 1'b0;
      w_load    = 1'b0;
    end
  end

  assign s_ready      = w_s_ready;
  assign push_n_iFIFO = ~w_push_i;
  assign din_iFIFO    = s_data;
  assign busy         = (r_state != ST_IDLE);
  assign pkt_done     = r_pkt_done;
  assign err_hdr      = r_err_hdr;

endmodule
